// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the memory port between the 6502 core and a DMA master.
// Rev 1.0 - burst cap, read-only CPU stall and a post-burst CPU cooldown window.
`default_nettype none

module mem_bus_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int COOLDOWN  = 2
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_we,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic [7:0]  burst_cnt
);

  localparam logic [1:0] S_CPU  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DMA  = 2'd2;
  localparam logic [1:0] S_COOL = 2'd3;

  localparam logic [3:0] C_COOL_LOAD = 4'(COOLDOWN - 1);
  localparam logic [8:0] C_MAX_BURST = 9'(MAX_BURST);

  logic [1:0] state_q, state_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic [3:0] cool_q, cool_d;
  logic       w_cap_hit;

  assign w_cap_hit = ({1'b0, burst_cnt_q} + 9'd1) == C_MAX_BURST;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    cool_d      = cool_q;
    case (state_q)
      S_CPU: begin
        if (dma_req) begin
          state_d     = S_WAIT;
          burst_cnt_d = 8'd0;
        end
      end
      S_WAIT: begin
        // RDY cannot stall a write, so the grant waits for a read cycle.
        if (!dma_req) begin
          state_d = S_CPU;
        end else if (!cpu_we) begin
          state_d = S_DMA;
        end
      end
      S_DMA: begin
        if (!dma_req) begin
          state_d = S_COOL;
          cool_d  = C_COOL_LOAD;
        end else begin
          if (burst_cnt_q != 8'hFF) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
          if (dma_last || w_cap_hit) begin
            state_d = S_COOL;
            cool_d  = C_COOL_LOAD;
          end
        end
      end
      S_COOL: begin
        if (cool_q == 4'd0) begin
          state_d = S_CPU;
        end else begin
          cool_d = cool_q - 4'd1;
        end
      end
      default: begin
        state_d = S_CPU;
      end
    endcase
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q     <= S_CPU;
      burst_cnt_q <= 8'd0;
      cool_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      cool_q      <= cool_d;
    end
  end

  // Bus steering depends only on registered state, never on dma_req.
  assign dma_gnt   = (state_q == S_DMA);
  assign cpu_rdy   = (state_q == S_CPU) || (state_q == S_COOL);
  assign mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
  assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
  assign mem_we    = dma_gnt ? dma_we    : cpu_we;
  assign burst_cnt = burst_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter.
// Rev 1.0
`default_nettype none

module tb_mem_bus_arbiter;

  logic        ph1 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_we = 1'b0;
  logic        cpu_rdy;
  logic        dma_req = 1'b0;
  logic [15:0] dma_addr = 16'h0000;
  logic [7:0]  dma_wdata = 8'h00;
  logic        dma_we = 1'b0;
  logic        dma_last = 1'b0;
  logic        dma_gnt;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  burst_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:255] = '{default: 8'h00};

  mem_bus_arbiter #(.MAX_BURST(16), .COOLDOWN(2)) dut (
    .ph1      (ph1),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_we   (cpu_we),
    .cpu_rdy  (cpu_rdy),
    .dma_req  (dma_req),
    .dma_addr (dma_addr),
    .dma_wdata(dma_wdata),
    .dma_we   (dma_we),
    .dma_last (dma_last),
    .dma_gnt  (dma_gnt),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .burst_cnt(burst_cnt)
  );

  always #5 ph1 = ~ph1;

  always @(posedge ph1) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge ph1);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cpu_addr = 16'h1234; cpu_wdata = 8'h11; cpu_we = 1'b0;
    dma_req = 1'b1; dma_addr = 16'hBEEF; dma_wdata = 8'h22; dma_we = 1'b1; dma_last = 1'b0;
    step; step; #1;
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", cpu_rdy); end
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", dma_gnt); end
    checks++; if (burst_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", burst_cnt); end
    checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL reset_addr: got %h expected 1234", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    dma_req = 1'b0; dma_we = 1'b0;
    reset = 1'b0;
    step;
  endtask

  task automatic test_basic_burst;
    logic exp_rdy, exp_gnt;
    logic [15:0] exp_addr;
    cpu_addr = 16'h0200; cpu_we = 1'b0;
    dma_we = 1'b1; dma_wdata = 8'hA5; dma_addr = 16'h0070; dma_req = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) step;
      if (c >= 2 && c <= 5) dma_addr = 16'h0070 + 16'(c - 2);
      dma_last = (c == 5);
      if (c == 6) begin dma_req = 1'b0; dma_we = 1'b0; end
      #1;
      exp_rdy  = !(c >= 1 && c <= 5);
      exp_gnt  = (c >= 2 && c <= 5);
      exp_addr = exp_gnt ? dma_addr : 16'h0200;
      checks++; if (cpu_rdy !== exp_rdy) begin errors++; $display("FAIL burst_rdy c%0d: got %b expected %b", c, cpu_rdy, exp_rdy); end
      checks++; if (dma_gnt !== exp_gnt) begin errors++; $display("FAIL burst_gnt c%0d: got %b expected %b", c, dma_gnt, exp_gnt); end
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL burst_addr c%0d: got %h expected %h", c, mem_addr, exp_addr); end
    end
    checks++; if (burst_cnt !== 8'd4) begin errors++; $display("FAIL burst_cnt: got %0d expected 4", burst_cnt); end
    for (int a = 8'h70; a <= 8'h73; a++) begin
      checks++; if (ram[a] !== 8'hA5) begin errors++; $display("FAIL burst_ram[%h]: got %h expected a5", a, ram[a]); end
    end
    checks++; if (ram[8'h74] !== 8'h00) begin errors++; $display("FAIL burst_ram_overrun: got %h expected 00", ram[8'h74]); end
    step;
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL burst_back_to_cpu: got %b expected 1", cpu_rdy); end
  endtask

  task automatic test_write_deferral;
    logic exp_rdy, exp_gnt, exp_we;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) step;
      cpu_addr = 16'h0071; cpu_we = (c <= 2); cpu_wdata = 8'h3C + 8'(c);
      dma_req = (c <= 4); dma_addr = 16'h0080; dma_we = 1'b0; dma_last = (c == 4);
      #1;
      exp_rdy = !(c >= 1 && c <= 4);
      exp_gnt = (c == 4);
      exp_we  = (c <= 2);
      checks++; if (cpu_rdy !== exp_rdy) begin errors++; $display("FAIL defer_rdy c%0d: got %b expected %b", c, cpu_rdy, exp_rdy); end
      checks++; if (dma_gnt !== exp_gnt) begin errors++; $display("FAIL defer_gnt c%0d: got %b expected %b", c, dma_gnt, exp_gnt); end
      checks++; if (mem_we !== exp_we) begin errors++; $display("FAIL defer_we c%0d: got %b expected %b", c, mem_we, exp_we); end
    end
    checks++; if (ram[8'h71] !== 8'h3E) begin errors++; $display("FAIL defer_ram: got %h expected 3e", ram[8'h71]); end
    checks++; if (burst_cnt !== 8'd1) begin errors++; $display("FAIL defer_cnt: got %0d expected 1", burst_cnt); end
    cpu_we = 1'b0;
    step;
  endtask

  task automatic test_burst_cap;
    logic exp_rdy, exp_gnt;
    int gnt_count = 0;
    for (int c = 0; c <= 21; c++) begin
      if (c > 0) step;
      dma_req = 1'b1; dma_we = 1'b1; dma_last = 1'b0;
      dma_addr = 16'h0090 + 16'(c); dma_wdata = 8'(c);
      cpu_we = 1'b0; cpu_addr = 16'h0300;
      #1;
      exp_gnt = (c >= 2 && c <= 17);
      exp_rdy = !(c >= 1 && c <= 17) && (c != 21);
      if (dma_gnt === 1'b1) gnt_count++;
      checks++; if (cpu_rdy !== exp_rdy) begin errors++; $display("FAIL cap_rdy c%0d: got %b expected %b", c, cpu_rdy, exp_rdy); end
      checks++; if (dma_gnt !== exp_gnt) begin errors++; $display("FAIL cap_gnt c%0d: got %b expected %b", c, dma_gnt, exp_gnt); end
      if (c == 18 || c == 20) begin
        checks++; if (burst_cnt !== 8'd16) begin errors++; $display("FAIL cap_cnt c%0d: got %0d expected 16", c, burst_cnt); end
      end
      if (c == 21) begin
        checks++; if (burst_cnt !== 8'd0) begin errors++; $display("FAIL cap_cnt_clear: got %0d expected 0", burst_cnt); end
      end
    end
    checks++; if (gnt_count != 16) begin errors++; $display("FAIL cap_gnt_count: got %0d expected 16", gnt_count); end
    dma_req = 1'b0; dma_we = 1'b0;
    step;
  endtask

  task automatic test_fairness;
    logic g, r, prev_g, phase, done;
    logic [7:0] wval, start_val;
    int incs = 0, bursts = 0, rdy_run = 0, xfer = 0, cyc = 0;
    prev_g = 1'b0; phase = 1'b0; done = 1'b0; wval = 8'h00;
    start_val = ram[8'h71];
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h00C0; dma_wdata = 8'h77;
    while (!done && cyc < 200) begin
      if (cyc > 0) step;
      cyc++;
      g = dma_gnt; r = cpu_rdy;
      dma_last = g && (xfer == 3);
      if (g) begin
        if (!prev_g) begin
          bursts++;
          if (bursts > 1) begin
            checks++; if (rdy_run != 3) begin errors++; $display("FAIL fair_gap burst%0d: got %0d rdy cycles expected 3", bursts, rdy_run); end
          end
        end
        rdy_run = 0;
        xfer++;
      end else begin
        xfer = 0;
        if (r) rdy_run++;
        if (prev_g && bursts == 3) done = 1'b1;
      end
      cpu_addr = 16'h0071; cpu_we = phase; cpu_wdata = wval;
      if (!phase) begin
        if (r) begin wval = ram[8'h71] + 8'd1; phase = 1'b1; end
      end else begin
        phase = 1'b0; incs++;
      end
      prev_g = g;
    end
    if (!done) begin
      checks++; errors++; $display("FAIL fair_timeout: got %0d bursts expected 3", bursts);
    end
    dma_req = 1'b0; dma_last = 1'b0; dma_we = 1'b0;
    #2; cpu_we = 1'b0;
    step; step; step;
    checks++; if (incs < 3) begin errors++; $display("FAIL fair_progress: got %0d incs expected >=3", incs); end
    checks++; if (ram[8'h71] !== 8'(start_val + 8'(incs))) begin errors++; $display("FAIL fair_ram: got %h expected %h", ram[8'h71], 8'(start_val + 8'(incs))); end
    checks++; if (burst_cnt !== 8'd4) begin errors++; $display("FAIL fair_cnt: got %0d expected 4", burst_cnt); end
  endtask

  task automatic test_withdrawal;
    logic exp_rdy;
    cpu_we = 1'b1; cpu_addr = 16'h0075; cpu_wdata = 8'h5A;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) step;
      dma_req = (c == 0);
      #1;
      exp_rdy = (c != 1);
      checks++; if (cpu_rdy !== exp_rdy) begin errors++; $display("FAIL wd_rdy c%0d: got %b expected %b", c, cpu_rdy, exp_rdy); end
      checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL wd_gnt c%0d: got %b expected 0", c, dma_gnt); end
      if (c >= 1) begin
        checks++; if (burst_cnt !== 8'd0) begin errors++; $display("FAIL wd_cnt c%0d: got %0d expected 0", c, burst_cnt); end
      end
    end
    checks++; if (ram[8'h75] !== 8'h5A) begin errors++; $display("FAIL wd_ram: got %h expected 5a", ram[8'h75]); end
    cpu_we = 1'b0;
    step;
  endtask

  task automatic test_reset_mid_burst;
    cpu_we = 1'b0; cpu_addr = 16'h0400;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h00D0; dma_wdata = 8'h99; dma_last = 1'b0;
    for (int c = 1; c <= 4; c++) step;
    checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rst_pre_gnt: got %b expected 1", dma_gnt); end
    checks++; if (burst_cnt !== 8'd2) begin errors++; $display("FAIL rst_pre_cnt: got %0d expected 2", burst_cnt); end
    #2; reset = 1'b1; #1;
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b expected 0", dma_gnt); end
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy: got %b expected 1", cpu_rdy); end
    checks++; if (mem_addr !== 16'h0400) begin errors++; $display("FAIL rst_addr: got %h expected 0400", mem_addr); end
    dma_req = 1'b0;
    @(posedge ph1); #2; reset = 1'b0; #1;
    checks++; if (burst_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", burst_cnt); end
    checks++; if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("FAIL rst_state: got rdy=%b gnt=%b expected rdy=1 gnt=0", cpu_rdy, dma_gnt); end
    step;
    dma_req = 1'b1; dma_last = 1'b1;
    step;
    checks++; if (cpu_rdy !== 1'b0 || dma_gnt !== 1'b0) begin errors++; $display("FAIL rst_lat_wait: got rdy=%b gnt=%b expected rdy=0 gnt=0", cpu_rdy, dma_gnt); end
    step;
    checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rst_lat_gnt: got %b expected 1", dma_gnt); end
    dma_req = 1'b0; dma_last = 1'b0; dma_we = 1'b0;
    step; step; step;
  endtask

  initial begin
    test_reset;
    test_basic_burst;
    test_write_deferral;
    test_burst_cap;
    test_fairness;
    test_withdrawal;
    test_reset_mid_burst;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
